// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - microprogram sequencer with 4-way branch, call/return stack and halt
//
// Purpose:
//   Presents the registered micro-address to an external combinational
//   microcode ROM, decodes the returned microword into the datapath control
//   bus, and selects the next micro-address. The next step is a 4-way
//   conditional branch, a subroutine call or return on an internal stack,
//   or a halt. The micro-address, the stack and the status flags are the
//   only state.
//
// Ports:
//   clk        in   1       rising-edge clock
//   rst_n      in   1       synchronous active-low reset
//   hold       in   1       1 = freeze sequencer this cycle
//   cond       in   NCOND   branch condition bits
//   uaddr      out  ADDR_W  current micro-address (registered upc)
//   uword      in   MW      ROM data at uaddr
//   bus_ctrl   out  CTRL_W  ctrl field of uword, 0 while halted
//   halted     out  1       sticky halt flag
//   stack_err  out  1       sticky stack overflow/underflow flag
//   sp         out  SP_W    number of valid stack entries

module micro_sequencer #(
  parameter int ADDR_W      = 4,
  parameter int CTRL_W      = 22,
  parameter int NCOND       = 4,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0,
  localparam int CSEL_W     = $clog2(NCOND),
  localparam int SP_W       = $clog2(STACK_DEPTH + 1),
  localparam int MW         = 2 + 2 * CSEL_W + 4 * ADDR_W + CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic [NCOND-1:0]  cond,
  output logic [ADDR_W-1:0] uaddr,
  input  logic [MW-1:0]     uword,
  output logic [CTRL_W-1:0] bus_ctrl,
  output logic              halted,
  output logic              stack_err,
  output logic [SP_W-1:0]   sp
);

  typedef enum logic [1:0] {
    OP_BRANCH = 2'b00,
    OP_CALL   = 2'b01,
    OP_RET    = 2'b10,
    OP_HALT   = 2'b11
  } op_e;

  // A depth-1 stack still needs a 1-bit index to declare the array.
  localparam int STK_IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0]   SP_FULL  = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0]   SP_ONE   = SP_W'(1);
  localparam logic [ADDR_W-1:0] RST_UPC  = ADDR_W'(RESET_ADDR);

  logic [ADDR_W-1:0] r_upc;
  logic [SP_W-1:0]   r_sp;
  logic              r_halted;
  logic              r_stack_err;
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

  // Microword fields, MSB to LSB: op | selA | selB | nxt0 | nxt1 | nxt2 | nxt3 | ctrl
  op_e               w_op;
  logic [CSEL_W-1:0] w_sela;
  logic [CSEL_W-1:0] w_selb;
  logic [ADDR_W-1:0] w_nxt0;
  logic [ADDR_W-1:0] w_nxt1;
  logic [ADDR_W-1:0] w_nxt2;
  logic [ADDR_W-1:0] w_nxt3;
  logic [CTRL_W-1:0] w_ctrl;

  assign w_op   = op_e'(uword[MW-1 -: 2]);
  assign w_sela = uword[CTRL_W + 4*ADDR_W + CSEL_W +: CSEL_W];
  assign w_selb = uword[CTRL_W + 4*ADDR_W +: CSEL_W];
  assign w_nxt0 = uword[CTRL_W + 3*ADDR_W +: ADDR_W];
  assign w_nxt1 = uword[CTRL_W + 2*ADDR_W +: ADDR_W];
  assign w_nxt2 = uword[CTRL_W + ADDR_W +: ADDR_W];
  assign w_nxt3 = uword[CTRL_W +: ADDR_W];
  assign w_ctrl = uword[CTRL_W-1:0];

  logic [1:0]        w_idx;
  logic [ADDR_W-1:0] w_br_target;
  logic [SP_W-1:0]   w_sp_dec;
  logic [STK_IDX_W-1:0] w_push_idx;
  logic [STK_IDX_W-1:0] w_top_idx;
  logic [ADDR_W-1:0] w_stack_top;

  // selB supplies the high index bit, selA the low one.
  assign w_idx = {cond[w_selb], cond[w_sela]};

  always_comb begin
    w_br_target = w_nxt0;
    case (w_idx)
      2'b00:   w_br_target = w_nxt0;
      2'b01:   w_br_target = w_nxt1;
      2'b10:   w_br_target = w_nxt2;
      default: w_br_target = w_nxt3;
    endcase
  end

  // Push writes at slot sp; the top of stack lives at slot sp-1.
  assign w_sp_dec    = r_sp - SP_ONE;
  assign w_push_idx  = r_sp[STK_IDX_W-1:0];
  assign w_top_idx   = w_sp_dec[STK_IDX_W-1:0];
  assign w_stack_top = r_stack[w_top_idx];

  logic [ADDR_W-1:0] w_upc_nxt;
  logic [SP_W-1:0]   w_sp_nxt;
  logic              w_push;
  logic              w_err_set;
  logic              w_halt_set;

  always_comb begin
    w_upc_nxt  = r_upc;
    w_sp_nxt   = r_sp;
    w_push     = 1'b0;
    w_err_set  = 1'b0;
    w_halt_set = 1'b0;
    if (!r_halted && !hold) begin
      case (w_op)
        OP_BRANCH: w_upc_nxt = w_br_target;
        OP_CALL: begin
          // The jump happens even when the push is refused on a full stack.
          w_upc_nxt = w_nxt0;
          if (r_sp != SP_FULL) begin
            w_push   = 1'b1;
            w_sp_nxt = r_sp + SP_ONE;
          end else begin
            w_err_set = 1'b1;
          end
        end
        OP_RET: begin
          if (r_sp != '0) begin
            w_upc_nxt = w_stack_top;
            w_sp_nxt  = w_sp_dec;
          end else begin
            w_upc_nxt = w_nxt0;
            w_err_set = 1'b1;
          end
        end
        default: w_halt_set = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_upc       <= RST_UPC;
      r_sp        <= '0;
      r_halted    <= 1'b0;
      r_stack_err <= 1'b0;
    end else begin
      r_upc       <= w_upc_nxt;
      r_sp        <= w_sp_nxt;
      r_halted    <= r_halted | w_halt_set;
      r_stack_err <= r_stack_err | w_err_set;
    end
  end

  // Stack contents need no reset; sp alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_stack[w_push_idx] <= w_nxt1;
    end
  end

  assign uaddr     = r_upc;
  assign sp        = r_sp;
  assign halted    = r_halted;
  assign stack_err = r_stack_err;
  assign bus_ctrl  = r_halted ? '0 : w_ctrl;

endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - directed scoreboard bench for micro_sequencer

module tb_micro_sequencer;

  localparam int ADDR_W = 4;
  localparam int CTRL_W = 22;
  localparam int NCOND  = 4;
  localparam int SP_W   = 3;
  localparam int MW     = 44;

  localparam logic [1:0] BR   = 2'b00;
  localparam logic [1:0] CALL = 2'b01;
  localparam logic [1:0] RET  = 2'b10;
  localparam logic [1:0] HALT = 2'b11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              hold;
  logic [NCOND-1:0]  cond;
  logic [ADDR_W-1:0] uaddr;
  logic [MW-1:0]     uword;
  logic [CTRL_W-1:0] bus_ctrl;
  logic              halted;
  logic              stack_err;
  logic [SP_W-1:0]   sp;

  logic [MW-1:0] rom [16];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string      tag;
    logic [3:0] addr;
    logic [2:0] sp;
    logic       h;
    logic       e;
  } exp_t;

  exp_t sb[$];

  micro_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (hold),
    .cond      (cond),
    .uaddr     (uaddr),
    .uword     (uword),
    .bus_ctrl  (bus_ctrl),
    .halted    (halted),
    .stack_err (stack_err),
    .sp        (sp)
  );

  always #5 clk = ~clk;

  assign uword = rom[uaddr];

  function automatic logic [CTRL_W-1:0] ctrl_of(input int a);
    return CTRL_W'(32'h2C0000 ^ (a * 32'h1357));
  endfunction

  function automatic logic [MW-1:0] mk(input logic [1:0] op, input int sa, input int sb_,
                                       input int n0, input int n1, input int n2, input int n3,
                                       input int a);
    return {op, 2'(sa), 2'(sb_), 4'(n0), 4'(n1), 4'(n2), 4'(n3), ctrl_of(a)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic step(input string tag, input logic r, input logic hd, input logic [1:0] c,
                      input int ea, input int es, input logic eh, input logic ee);
    exp_t x;
    x.tag  = tag;
    x.addr = 4'(ea);
    x.sp   = 3'(es);
    x.h    = eh;
    x.e    = ee;
    sb.push_back(x);
    rst_n = r;
    hold  = hd;
    cond  = {2'($urandom), c};
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check({x.tag, "/uaddr"},     32'(uaddr),     32'(x.addr));
    check({x.tag, "/sp"},        32'(sp),        32'(x.sp));
    check({x.tag, "/halted"},    32'(halted),    32'(x.h));
    check({x.tag, "/stack_err"}, 32'(stack_err), 32'(x.e));
    check({x.tag, "/bus_ctrl"},  32'(bus_ctrl),  x.h ? 32'd0 : 32'(ctrl_of(int'(x.addr))));
  endtask

  initial begin
    rst_n = 1'b0;
    hold  = 1'b1;
    cond  = '0;
    for (int a = 0; a < 16; a++) rom[a] = mk(BR, 0, 0, 0, 0, 0, 0, a);
    rom[0] = mk(BR, 0, 1, 4, 5, 6, 7, 0);
    #1;

    // Reset, including reset overriding hold
    step("rst_a", 1'b0, 1'b1, 2'($urandom), 0, 0, 1'b0, 1'b0);
    step("rst_b", 1'b0, 1'b0, 2'($urandom), 0, 0, 1'b0, 1'b0);

    // 4-way branch: idx = {cond[1], cond[0]}
    step("br00",  1'b1, 1'b0, 2'b00, 4, 0, 1'b0, 1'b0);
    step("back0", 1'b1, 1'b0, 2'($urandom), 0, 0, 1'b0, 1'b0);
    step("br01",  1'b1, 1'b0, 2'b01, 5, 0, 1'b0, 1'b0);
    step("back1", 1'b1, 1'b0, 2'($urandom), 0, 0, 1'b0, 1'b0);
    step("br10",  1'b1, 1'b0, 2'b10, 6, 0, 1'b0, 1'b0);
    step("back2", 1'b1, 1'b0, 2'($urandom), 0, 0, 1'b0, 1'b0);
    step("br11",  1'b1, 1'b0, 2'b11, 7, 0, 1'b0, 1'b0);
    step("back3", 1'b1, 1'b0, 2'($urandom), 0, 0, 1'b0, 1'b0);

    // Nested calls
    rom[0]  = mk(CALL, 0, 0, 8, 1, 0, 0, 0);
    rom[8]  = mk(CALL, 0, 0, 9, 10, 0, 0, 8);
    rom[9]  = mk(RET,  0, 0, 0, 0, 0, 0, 9);
    rom[10] = mk(RET,  0, 0, 0, 0, 0, 0, 10);
    rom[1]  = mk(BR,   0, 0, 1, 1, 1, 1, 1);
    step("call1", 1'b1, 1'b0, 2'($urandom), 8, 1, 1'b0, 1'b0);
    step("call2", 1'b1, 1'b0, 2'($urandom), 9, 2, 1'b0, 1'b0);
    step("ret1",  1'b1, 1'b0, 2'($urandom), 10, 1, 1'b0, 1'b0);
    step("ret2",  1'b1, 1'b0, 2'($urandom), 1, 0, 1'b0, 1'b0);

    // Overflow: fifth CALL is refused but still jumps
    step("rst_ov", 1'b0, 1'b0, 2'($urandom), 0, 0, 1'b0, 1'b0);
    rom[0]  = mk(CALL, 0, 0, 2, 14, 0, 0, 0);
    rom[2]  = mk(CALL, 0, 0, 3, 15, 0, 0, 2);
    rom[3]  = mk(CALL, 0, 0, 11, 4, 0, 0, 3);
    rom[11] = mk(CALL, 0, 0, 12, 5, 0, 0, 11);
    rom[12] = mk(CALL, 0, 0, 13, 6, 0, 0, 12);
    rom[13] = mk(RET,  0, 0, 0, 0, 0, 0, 13);
    step("ov1",    1'b1, 1'b0, 2'($urandom), 2, 1, 1'b0, 1'b0);
    step("ov2",    1'b1, 1'b0, 2'($urandom), 3, 2, 1'b0, 1'b0);
    step("ov3",    1'b1, 1'b0, 2'($urandom), 11, 3, 1'b0, 1'b0);
    step("ov4",    1'b1, 1'b0, 2'($urandom), 12, 4, 1'b0, 1'b0);
    step("ov5",    1'b1, 1'b0, 2'($urandom), 13, 4, 1'b0, 1'b1);
    step("ov_ret", 1'b1, 1'b0, 2'($urandom), 5, 3, 1'b0, 1'b1);
    step("ov_br",  1'b1, 1'b0, 2'($urandom), 0, 3, 1'b0, 1'b1);

    // Underflow
    step("rst_un", 1'b0, 1'b0, 2'($urandom), 0, 0, 1'b0, 1'b0);
    rom[0]  = mk(RET,  0, 0, 3, 0, 0, 0, 0);
    rom[3]  = mk(CALL, 0, 0, 15, 9, 0, 0, 3);
    rom[15] = mk(HALT, 0, 0, 0, 0, 0, 0, 15);
    step("under",  1'b1, 1'b0, 2'($urandom), 3, 0, 1'b0, 1'b1);

    // Hold, halt, then reset out of halt
    step("hold1",  1'b1, 1'b1, 2'($urandom), 3, 0, 1'b0, 1'b1);
    step("hold2",  1'b1, 1'b1, 2'($urandom), 3, 0, 1'b0, 1'b1);
    step("hold3",  1'b1, 1'b1, 2'($urandom), 3, 0, 1'b0, 1'b1);
    step("unhold", 1'b1, 1'b0, 2'($urandom), 15, 1, 1'b0, 1'b1);
    step("halt",   1'b1, 1'b0, 2'($urandom), 15, 1, 1'b1, 1'b1);
    step("halt_f", 1'b1, 1'b0, 2'($urandom), 15, 1, 1'b1, 1'b1);
    step("halt_h", 1'b1, 1'b1, 2'($urandom), 15, 1, 1'b1, 1'b1);
    step("rst_h",  1'b0, 1'b1, 2'($urandom), 0, 0, 1'b0, 1'b0);
    step("post",   1'b1, 1'b0, 2'($urandom), 3, 0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
